imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Upstream loader for the mips_16 single-cycle core. It accepts a byte stream carrying a program image and assembles it into 16-bit instruction words. Each word is written into the instruction memory write port. The loader holds the core in reset until the image is loaded and checksum-verified, then releases it. It replaces hard-coded instruction ROM contents for bench and board bring-up.

## Interface
Parameters:
- ADDR_W, 4, instruction memory address width; depth DEPTH = 2**ADDR_W words
- HOLD_CYCLES, 4, cycles cpu_reset stays asserted after checksum pass (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address for imem_we
- imem_wdata  out  16  instruction word for imem_we
- cpu_reset  out  1  active-high reset to mips_16
- done  out  1  image loaded, core running
- error  out  1  bad header or checksum; sticky until reset
- words_loaded  out  ADDR_W+1  count of words written this load

## Operation
- Byte accepted on a rising edge with in_valid & in_ready. No other byte is consumed.
- Frame format: header byte N (word count), then 2N payload bytes, then one checksum byte.
  - Payload words are high byte first.
  - Checksum is the XOR of all 2N payload bytes; the header is excluded.
- States: IDLE, LOAD_HI, LOAD_LO, CHECK, HOLD, RUN, ERR.
- in_ready is combinational from state: 1 in IDLE/LOAD_HI/LOAD_LO/CHECK, 0 in HOLD/RUN/ERR.
- IDLE: on accept, if 1 ≤ N ≤ DEPTH latch N, clear index/checksum → LOAD_HI; else → ERR.
- LOAD_HI: on accept, latch high byte, xor into checksum → LOAD_LO.
- LOAD_LO: on accept:
  - xor into checksum;
  - register imem_we=1, imem_addr=index, imem_wdata={hi,lo};
  - index++, words_loaded++;
  - → LOAD_HI if index+1 < N, else → CHECK.
- CHECK: on accept, compare the byte to the running checksum. Match → HOLD, loading the hold counter with HOLD_CYCLES-1. Mismatch → ERR.
- HOLD: counter decrements each cycle; at 0 → RUN, cpu_reset<=0, done<=1.
- RUN: terminal. cpu_reset=0, done=1; stream ignored. A new load requires reset.
- ERR: terminal. error=1, cpu_reset=1, no writes. Exit only via reset.
- Memory is never cleared. Words beyond N keep prior contents.

## Timing
- Reset values (any cycle with reset=0):
  - state IDLE;
  - cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, words_loaded=0;
  - checksum, index and hold counter all 0.
- in_ready=1 in the first cycle after reset releases.
- imem_we is registered. It is high exactly the one cycle following the edge that accepted a low byte, otherwise 0. imem_addr/imem_wdata are valid when imem_we=1.
- Minimum load: 2N+2 accepted bytes, i.e. 2N+2 cycles with continuous in_valid. Bubbles on in_valid only stall; they never change state.
- If the checksum byte is accepted at edge k, cpu_reset falls and done rises at edge k+HOLD_CYCLES.
- The last imem write (cycle after edge k-1) always completes before cpu_reset falls.
- ERR entered at edge k: error=1 and in_ready=0 from edge k on.
- Reset mid-frame: load aborts at that edge and cpu_reset returns to 1. Partially written words remain; the next frame overwrites from address 0.
- Reset while in RUN: core is reset again and the loader awaits a new header.

## Test plan
- Load N=3, HOLD_CYCLES=4: bytes 03 12 34 AB CD 00 01 41 → three imem_we pulses: addr0=0x1234, addr1=0xABCD, addr2=0x0001. words_loaded=3. cpu_reset falls and done=1 exactly 4 edges after 0x41 accepted.
- Same frame with checksum 0x40 → error=1, cpu_reset stays 1, in_ready=0, done=0. Further in_valid produces no imem_we.
- Header 0x00, and separately header 0x11 (17 > DEPTH=16) → ERR on the next edge, zero imem_we pulses.
- Frame from the first test with in_valid dropped for 1–3 random cycles between bytes → identical write sequence and checksum pass. in_valid held high in RUN → no writes, in_ready=0.
- Reset asserted after the header and one payload byte → IDLE, cpu_reset=1, no write issued. Then a full N=16 frame → writes addr 0..15 in order, words_loaded=16, done=1.
- reset low for one cycle while in RUN → cpu_reset=1, done=0, in_ready=1 on the next cycle. A second N=1 frame 01 00 07 07 → addr0=0x0007, done=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader for the mips_16 core: assembles {hi,lo} words into
// instruction memory, verifies an XOR checksum, then releases the core from reset.
module imem_boot_loader #(
    parameter int ADDR_W      = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        CHECK,
        HOLD,
        RUN,
        ERR
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  word_count;
    logic [CNT_W-1:0]  index;
    logic [CNT_W-1:0]  index_next;
    logic [7:0]        hi_byte;
    logic [7:0]        checksum;
    logic [HOLD_W-1:0] hold_cnt;
    logic              accept;
    logic              header_ok;

    assign in_ready = (state == IDLE) || (state == LOAD_HI) ||
                      (state == LOAD_LO) || (state == CHECK);
    assign accept       = in_valid && in_ready;
    assign header_ok    = (in_data != 8'd0) && (int'(in_data) <= DEPTH);
    assign index_next   = index + CNT_W'(1);
    // Every accepted low byte writes exactly one word, so the index doubles as the count.
    assign words_loaded = index;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            word_count <= '0;
            index      <= '0;
            hi_byte    <= '0;
            checksum   <= '0;
            hold_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (header_ok) begin
                            word_count <= CNT_W'(in_data);
                            index      <= '0;
                            checksum   <= '0;
                            state      <= LOAD_HI;
                        end else begin
                            error <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                LOAD_HI: begin
                    if (accept) begin
                        hi_byte  <= in_data;
                        checksum <= checksum ^ in_data;
                        state    <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (accept) begin
                        checksum   <= checksum ^ in_data;
                        imem_we    <= 1'b1;
                        imem_addr  <= index[ADDR_W-1:0];
                        imem_wdata <= {hi_byte, in_data};
                        index      <= index_next;
                        state      <= (index_next < word_count) ? LOAD_HI : CHECK;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (in_data == checksum) begin
                            hold_cnt <= HOLD_LOAD;
                            state    <= HOLD;
                        end else begin
                            error <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                RUN: begin
                    cpu_reset <= 1'b0;
                    done      <= 1'b1;
                end
                ERR: begin
                    error     <= 1'b1;
                    cpu_reset <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output invariants that hold in every reachable state.
    done_releases_core: assert property (@(posedge clk) disable iff (!reset)
        done |-> (!cpu_reset && !error));
    error_holds_core: assert property (@(posedge clk) disable iff (!reset)
        error |-> cpu_reset);
    write_only_while_loading: assert property (@(posedge clk) disable iff (!reset)
        imem_we |-> (!error && !done && cpu_reset));

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a frame-level model predicts writes and
// outcome; a negedge monitor checks every imem write against the expected queue.
module tb_imem_boot_loader;

    localparam int ADDR_W      = 4;
    localparam int HOLD_CYCLES = 4;
    localparam int DEPTH       = 2 ** ADDR_W;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int  checks   = 0;
    int  failures = 0;
    wr_t exp_q[$];

    imem_boot_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        wr_t w;
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%04h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", imem_addr, w.addr);
                check("wr_data", imem_wdata, w.data);
            end
        end
    end

    // Frame-level reference: parse header, pair payload bytes, XOR-check the trailer.
    task automatic model(input byte_q_t fr, output bit exp_err, output int exp_words);
        int         n;
        logic [7:0] x;
        n = int'(fr[0]);
        x = 8'h00;
        if (n < 1 || n > DEPTH) begin
            exp_err   = 1'b1;
            exp_words = 0;
            return;
        end
        for (int w = 0; w < n; w++) begin
            x ^= fr[1 + 2 * w] ^ fr[2 + 2 * w];
            exp_q.push_back('{addr: w, data: int'({fr[1 + 2 * w], fr[2 + 2 * w]})});
        end
        exp_err   = (fr[2 * n + 1] != x);
        exp_words = n;
    endtask

    task automatic make_frame(input int n, input bit corrupt, output byte_q_t fr);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        fr = {};
        fr.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            x ^= b;
            fr.push_back(b);
        end
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
    endtask

    // Drives bytes at negedges; stops early once the loader no longer accepts.
    task automatic send_frame(input byte_q_t fr, input bit bubbles);
        foreach (fr[i]) begin
            if (bubbles && i > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end
            @(negedge clk);
            if (in_ready !== 1'b1) break;
            in_valid = 1'b1;
            in_data  = fr[i];
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles, input bit chk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        if (chk) begin
            check("rst_cpu_reset", cpu_reset, 1);
            check("rst_imem_we", imem_we, 0);
            check("rst_imem_addr", imem_addr, 0);
            check("rst_imem_wdata", imem_wdata, 0);
            check("rst_done", done, 0);
            check("rst_error", error, 0);
            check("rst_words_loaded", words_loaded, 0);
            check("rst_in_ready", in_ready, 1);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        if (chk) check("ready_after_release", in_ready, 1);
    endtask

    task automatic run_frame(input string tag, input byte_q_t fr, input bit bubbles);
        bit exp_err;
        int exp_words;
        int lat_done;
        int lat_rst;
        model(fr, exp_err, exp_words);
        send_frame(fr, bubbles);
        check({tag, "_words"}, words_loaded, exp_words);
        check({tag, "_error"}, error, exp_err);
        if (exp_err) begin
            check({tag, "_err_cpu_reset"}, cpu_reset, 1);
            check({tag, "_err_in_ready"}, in_ready, 0);
            check({tag, "_err_done"}, done, 0);
            in_valid = 1'b1;
            in_data  = 8'hA5;
            repeat (5) @(negedge clk);
            in_valid = 1'b0;
            check({tag, "_err_sticky"}, error, 1);
        end else begin
            lat_done = 0;
            lat_rst  = 0;
            for (int i = 1; i <= HOLD_CYCLES + 4; i++) begin
                @(posedge clk);
                #1;
                if (lat_rst == 0 && cpu_reset === 1'b0) lat_rst = i;
                if (done === 1'b1) begin
                    lat_done = i;
                    break;
                end
            end
            check({tag, "_done_latency"}, lat_done, HOLD_CYCLES);
            check({tag, "_cpu_reset_latency"}, lat_rst, HOLD_CYCLES);
            in_valid = 1'b1;
            in_data  = 8'h5A;
            repeat (3) begin
                @(negedge clk);
                check({tag, "_run_in_ready"}, in_ready, 0);
            end
            in_valid = 1'b0;
            check({tag, "_run_done"}, done, 1);
        end
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        byte_q_t fr;
        byte_q_t t1;
        t1 = '{8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h41};

        do_reset(2, 1);
        run_frame("basic", t1, 1'b0);

        do_reset(1, 0);
        fr = t1;
        fr[7] = 8'h40;
        run_frame("bad_cks", fr, 1'b0);

        do_reset(1, 0);
        fr = '{8'h00};
        run_frame("hdr_zero", fr, 1'b0);

        do_reset(1, 0);
        fr = '{8'h11};
        run_frame("hdr_big", fr, 1'b0);

        do_reset(1, 0);
        run_frame("bubbles", t1, 1'b1);

        // Abort after header and one payload byte: no write may appear.
        do_reset(1, 0);
        fr = '{8'h03, 8'h12};
        send_frame(fr, 1'b0);
        do_reset(1, 1);
        make_frame(DEPTH, 1'b0, fr);
        run_frame("full", fr, 1'b0);

        // Reset straight out of RUN, then a minimal one-word image.
        do_reset(1, 1);
        fr = '{8'h01, 8'h00, 8'h07, 8'h07};
        run_frame("n1", fr, 1'b0);

        for (int r = 0; r < 6; r++) begin
            do_reset(1, 0);
            make_frame(int'($urandom_range(1, DEPTH)), ($urandom_range(0, 2) == 0), fr);
            run_frame("rand", fr, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
